// File: rtl/main_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS main controller and the ALU-control stage.
package main_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] en_uc;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/main_ctrl_outdec.sv
// State to control-vector decoder; Moore except the FETCH IR/PC write strobes.
module main_ctrl_outdec
  import main_ctrl_fsm_pkg::*;
(
  input  state_e     state_i,
  input  logic       mem_ready_i,
  input  logic       rst_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.en_uc     = ALU_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = 2'b11;
        ctrl_o.en_uc     = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.en_uc     = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.ior_d     = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.en_uc     = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.en_uc         = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = 2'b10;
      end
      default: ctrl_o = '0;
    endcase
    // Reset silences every strobe immediately, not just after the edge.
    if (rst_i) ctrl_o = '0;
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic and sticky illegal-op flag.
module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       err,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [2:0] En_UC,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  ctrl_t  ctrl;

  // The branch decision is made in the datapath; the flag only passes by here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        if (ILLEGAL_TRAP && !is_known_op(opcode)) err_d = 1'b1;
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  main_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .rst_i       (rst),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign En_UC       = ctrl.en_uc;
  assign err         = err_q & ~rst;
  assign state_o     = state_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed scoreboard bench for main_ctrl_fsm: per-cycle expected control words.
module tb_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA, err;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] En_UC;
  logic [3:0] state_o;

  main_ctrl_fsm #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .err(err), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .En_UC(En_UC), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Word: {err, PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,RegDst,ALUSrcA,
  //        PCSource, ALUSrcB, En_UC, state}
  localparam logic [20:0] F1   = {10'b1001010000, 2'b00, 2'b01, 3'b001, 4'd0};
  localparam logic [20:0] F0   = {10'b0001000000, 2'b00, 2'b01, 3'b001, 4'd0};
  localparam logic [20:0] DEC  = {10'b0000000000, 2'b00, 2'b11, 3'b001, 4'd1};
  localparam logic [20:0] MADR = {10'b0000000001, 2'b00, 2'b10, 3'b001, 4'd2};
  localparam logic [20:0] MRD  = {10'b0011000000, 2'b00, 2'b00, 3'b000, 4'd3};
  localparam logic [20:0] MWB  = {10'b0000001100, 2'b00, 2'b00, 3'b000, 4'd4};
  localparam logic [20:0] MWR  = {10'b0010100000, 2'b00, 2'b00, 3'b000, 4'd5};
  localparam logic [20:0] REX  = {10'b0000000001, 2'b00, 2'b00, 3'b000, 4'd6};
  localparam logic [20:0] RWB  = {10'b0000000110, 2'b00, 2'b00, 3'b000, 4'd7};
  localparam logic [20:0] IEX  = {10'b0000000001, 2'b00, 2'b10, 3'b001, 4'd8};
  localparam logic [20:0] IWB  = {10'b0000000100, 2'b00, 2'b00, 3'b000, 4'd9};
  localparam logic [20:0] BR   = {10'b0100000001, 2'b01, 2'b00, 3'b010, 4'd10};
  localparam logic [20:0] JMP  = {10'b1000000000, 2'b10, 2'b00, 3'b000, 4'd11};
  localparam logic [20:0] RST0 = {10'b0000000000, 2'b00, 2'b00, 3'b000, 4'd0};
  localparam logic [20:0] RSTW = {10'b0000000000, 2'b00, 2'b00, 3'b000, 4'd5};

  typedef struct {
    logic [21:0] word;
    int          step;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   step_n = 0;

  task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                     input logic e, input logic [20:0] w);
    exp_t x;
    rst       = r;
    opcode    = op;
    mem_ready = mr;
    zero      = ~zero;
    x.word    = {e, w};
    x.step    = step_n;
    step_n++;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [21:0] act;
      x   = q.pop_front();
      act = {err, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, En_UC, state_o};
      tests++;
      if (act !== x.word) begin
        fails++;
        $display("FAIL step%0d ctrl_word: got %h expected %h", x.step, act, x.word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset state
    cyc(1, 6'b000000, 1, 0, RST0);
    // R-type
    cyc(0, 6'b000000, 1, 0, F1);
    cyc(0, 6'b000000, 1, 0, DEC);
    cyc(0, 6'b000000, 1, 0, REX);
    cyc(0, 6'b000000, 1, 0, RWB);
    // lw with memory stalled two cycles in MEM_RD
    cyc(0, 6'b100011, 1, 0, F1);
    cyc(0, 6'b100011, 1, 0, DEC);
    cyc(0, 6'b100011, 1, 0, MADR);
    cyc(0, 6'b100011, 0, 0, MRD);
    cyc(0, 6'b100011, 0, 0, MRD);
    cyc(0, 6'b100011, 1, 0, MRD);
    cyc(0, 6'b100011, 1, 0, MWB);
    // beq
    cyc(0, 6'b000100, 1, 0, F1);
    cyc(0, 6'b000100, 1, 0, DEC);
    cyc(0, 6'b000100, 1, 0, BR);
    // sw
    cyc(0, 6'b101011, 1, 0, F1);
    cyc(0, 6'b101011, 1, 0, DEC);
    cyc(0, 6'b101011, 1, 0, MADR);
    cyc(0, 6'b101011, 1, 0, MWR);
    // addi
    cyc(0, 6'b001000, 1, 0, F1);
    cyc(0, 6'b001000, 1, 0, DEC);
    cyc(0, 6'b001000, 1, 0, IEX);
    cyc(0, 6'b001000, 1, 0, IWB);
    // FETCH stalled three cycles, then j
    cyc(0, 6'b000010, 0, 0, F0);
    cyc(0, 6'b000010, 0, 0, F0);
    cyc(0, 6'b000010, 0, 0, F0);
    cyc(0, 6'b000010, 1, 0, F1);
    cyc(0, 6'b000010, 1, 0, DEC);
    cyc(0, 6'b000010, 1, 0, JMP);
    // Illegal opcode: back to FETCH, err sticky afterwards
    cyc(0, 6'b111111, 1, 0, F1);
    cyc(0, 6'b111111, 1, 0, DEC);
    cyc(0, 6'b000000, 1, 1, F1);
    cyc(0, 6'b000000, 1, 1, DEC);
    cyc(0, 6'b000000, 1, 1, REX);
    cyc(0, 6'b000000, 1, 1, RWB);
    // sw stalled in MEM_WR, reset mid-wait
    cyc(0, 6'b101011, 1, 1, F1);
    cyc(0, 6'b101011, 1, 1, DEC);
    cyc(0, 6'b101011, 1, 1, MADR);
    cyc(0, 6'b101011, 0, 1, MWR);
    cyc(1, 6'b101011, 0, 0, RSTW);
    cyc(1, 6'b101011, 0, 0, RST0);
    cyc(0, 6'b101011, 0, 0, F0);
    cyc(0, 6'b101011, 1, 0, F1);
    cyc(0, 6'b101011, 1, 0, DEC);
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 1; 1 = unknown opcode sets sticky err and returns to FETCH, 0 = unknown opcode treated as NOP.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have ports: opcode input 6 (IR[31:26]); mem_ready input 1 (memory handshake, access completes in a cycle where 1); zero input 1 (ALU zero flag).
REQ-005 SHALL have 1-bit outputs: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, err.
REQ-006 SHALL have outputs PCSource 2 bits, ALUSrcB 2 bits, En_UC 3 bits (ALU-op code to the ALU-control stage), state_o 4 bits (debug).

Function
REQ-007 SHALL implement a multicycle MIPS control FSM: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-008 SHALL decode opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 000010 j, 001000 addi.
REQ-009 En_UC encoding SHALL be: 000 = decode funct (R_EXEC only), 001 = ADD, 010 = SUB; all other values never driven.
REQ-010 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, En_UC=001, PCSource=00; IRWrite=PCWrite=mem_ready; stays until mem_ready=1, then DECODE.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, En_UC=001 (branch target); next: lw/sw->MEM_ADDR, R->R_EXEC, addi->I_EXEC, beq->BRANCH, j->JUMP, other->FETCH.
REQ-012 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, En_UC=001; lw->MEM_RD, sw->MEM_WR.
REQ-013 MEM_RD: MemRead=1, IorD=1; waits for mem_ready, then MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
REQ-014 MEM_WR: MemWrite=1, IorD=1 held until the mem_ready=1 cycle; then FETCH.
REQ-015 R_EXEC: ALUSrcA=1, ALUSrcB=00, En_UC=000; ->R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
REQ-016 I_EXEC: ALUSrcA=1, ALUSrcB=10, En_UC=001; ->I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, En_UC=010, PCWriteCond=1, PCSource=01; ->FETCH (PC update gated by zero in datapath).
REQ-018 JUMP: PCWrite=1, PCSource=10; ->FETCH.
REQ-019 Outputs not listed for a state SHALL be 0; outputs SHALL be Moore (state only) except IRWrite/PCWrite in FETCH.
REQ-020 Latency: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3, with mem_ready=1 throughout; each mem_ready=0 cycle adds one.
REQ-021 Unknown opcode in DECODE with ILLEGAL_TRAP=1 SHALL set err on the next edge; err stays 1 until reset.
REQ-022 state_o SHALL equal the encoded current state; FETCH=0.

Reset
REQ-023 rst=1 at an edge SHALL force state to FETCH and err to 0, from any state including mid-wait.
REQ-024 While rst=1 all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) SHALL be 0 combinationally; other outputs 0.

Structure
REQ-025 State encodings, opcode constants and En_UC codes SHALL live in a shared package, reused by the ALU-control stage.
REQ-026 One sub-module SHALL be natural: main_ctrl_outdec (state -> control vector decoder); next-state logic stays in main_ctrl_fsm.

Verification
REQ-027 Reset, then opcode 000000, mem_ready=1 -> states 0,DECODE,R_EXEC,R_WB,0; En_UC=000 in R_EXEC; RegWrite=1 and RegDst=1 only in R_WB.
REQ-028 lw (100011), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, MemRead=1 and IorD=1 throughout, RegWrite=1 and MemtoReg=1 in MEM_WB.
REQ-029 beq (000100) -> En_UC=010, PCWriteCond=1, PCSource=01 in BRANCH; back to FETCH after 3 cycles total.
REQ-030 Opcode 111111, ILLEGAL_TRAP=1 -> DECODE->FETCH, err=1 next cycle and stays 1 across further instructions until rst.
REQ-031 rst asserted during MEM_WR with mem_ready=0 -> next edge state_o=0, MemWrite=0 during and after reset, err=0.
REQ-032 FETCH with mem_ready=0 for 3 cycles -> IRWrite=PCWrite=0 those cycles, =1 in the mem_ready=1 cycle, then DECODE.
